// File: rtl/arbitro_rr7.sv
// Round-robin arbiter for 7 requesters sharing the one-hot encoder datapath.
// A grant is held until the owner releases it, drops its request, or hits the hold limit.
module arbitro_rr7 #(
    parameter int MAX_HOLD = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] solicitud,
    input  logic       liberar,
    output logic [6:0] concesion,
    output logic [2:0] codigo,
    output logic       ocupado,
    output logic       expirado
);

    localparam logic       LIBRE     = 1'b0;
    localparam logic       CONCEDIDO = 1'b1;
    localparam logic [7:0] HOLD_LAST = (MAX_HOLD > 0) ? 8'(MAX_HOLD - 1) : 8'd0;

    logic       r_state;
    logic [2:0] r_ptr;
    logic [7:0] r_cnt;
    logic [6:0] r_concesion;
    logic [2:0] r_codigo;
    logic       r_ocupado;
    logic       r_expirado;

    logic       w_found;
    logic [2:0] w_sel;
    logic       w_own_req;
    logic       w_tmo;
    logic       w_rel;

    // Rotated priority search starting just after the last owner.
    always_comb begin
        logic [3:0] v_sum;
        w_found = 1'b0;
        w_sel   = 3'd0;
        v_sum   = 4'd0;
        for (int i = 1; i <= 7; i++) begin
            v_sum = {1'b0, r_ptr} + 4'(i);
            if (v_sum >= 4'd7) v_sum = v_sum - 4'd7;
            if (!w_found && solicitud[v_sum[2:0]]) begin
                w_found = 1'b1;
                w_sel   = v_sum[2:0];
            end
        end
    end

    // r_ptr doubles as the current owner index while a grant is held.
    assign w_own_req = solicitud[r_ptr];
    assign w_tmo     = (MAX_HOLD != 0) && (r_cnt == HOLD_LAST);
    assign w_rel     = liberar | ~w_own_req | w_tmo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= LIBRE;
            r_ptr       <= 3'd6;
            r_cnt       <= 8'd0;
            r_concesion <= 7'd0;
            r_codigo    <= 3'd0;
            r_ocupado   <= 1'b0;
            r_expirado  <= 1'b0;
        end else begin
            r_expirado <= 1'b0;
            if (r_state == LIBRE) begin
                if (w_found) begin
                    r_concesion <= 7'(1) << w_sel;
                    r_codigo    <= w_sel + 3'd1;
                    r_ptr       <= w_sel;
                    r_cnt       <= 8'd0;
                    r_ocupado   <= 1'b1;
                    r_state     <= CONCEDIDO;
                end
            end else begin
                if (w_rel) begin
                    r_concesion <= 7'd0;
                    r_codigo    <= 3'd0;
                    r_ocupado   <= 1'b0;
                    // Timeout only counts as expiry when nothing else ended the grant.
                    r_expirado  <= w_tmo & ~liberar & w_own_req;
                    r_state     <= LIBRE;
                end else if (r_cnt != 8'hFF) begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end
        end
    end

    assign concesion = r_concesion;
    assign codigo    = r_codigo;
    assign ocupado   = r_ocupado;
    assign expirado  = r_expirado;

endmodule

// File: tb/tb_arbitro_rr7.sv
// Directed bench for arbitro_rr7: three instances with hold limits 15, 3 and 0.
module tb_arbitro_rr7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] sol_a = '0, sol_b = '0, sol_c = '0;
    logic       lib_a = 1'b0, lib_b = 1'b0, lib_c = 1'b0;
    logic [6:0] con_a, con_b, con_c;
    logic [2:0] cod_a, cod_b, cod_c;
    logic       ocu_a, ocu_b, ocu_c;
    logic       exp_a, exp_b, exp_c;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    arbitro_rr7 #(.MAX_HOLD(15)) u_a (
        .clk(clk), .rst(rst), .solicitud(sol_a), .liberar(lib_a),
        .concesion(con_a), .codigo(cod_a), .ocupado(ocu_a), .expirado(exp_a));
    arbitro_rr7 #(.MAX_HOLD(3)) u_b (
        .clk(clk), .rst(rst), .solicitud(sol_b), .liberar(lib_b),
        .concesion(con_b), .codigo(cod_b), .ocupado(ocu_b), .expirado(exp_b));
    arbitro_rr7 #(.MAX_HOLD(0)) u_c (
        .clk(clk), .rst(rst), .solicitud(sol_c), .liberar(lib_c),
        .concesion(con_c), .codigo(cod_c), .ocupado(ocu_c), .expirado(exp_c));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Reset values, then idle bus for 10 cycles
        do_reset();
        chk("rst_con", 8'(con_a), 8'h00);
        chk("rst_cod", 8'(cod_a), 8'h00);
        chk("rst_ocu", 8'(ocu_a), 8'h00);
        chk("rst_exp", 8'(exp_a), 8'h00);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_con", 8'(con_a), 8'h00);
            chk("idle_cod", 8'(cod_a), 8'h00);
            chk("idle_ocu", 8'(ocu_a), 8'h00);
        end

        // All requesting, owner releases one cycle after each grant
        do_reset();
        sol_a = 7'h7F;
        for (int g = 0; g < 8; g++) begin
            step();
            chk("rr_cod", 8'(cod_a), 8'((g % 7) + 1));
            chk("rr_con", 8'(con_a), 8'(1 << (g % 7)));
            chk("rr_ocu", 8'(ocu_a), 8'h01);
            lib_a = 1'b1;
            step();
            lib_a = 1'b0;
            chk("rr_gap_con", 8'(con_a), 8'h00);
            chk("rr_gap_ocu", 8'(ocu_a), 8'h00);
        end
        sol_a = '0;

        // Timeout with MAX_HOLD=3
        do_reset();
        sol_b = 7'b0010100;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("tmo_con", 8'(con_b), 8'h04);
            chk("tmo_cod", 8'(cod_b), 8'h03);
            chk("tmo_exp0", 8'(exp_b), 8'h00);
        end
        step();
        chk("tmo_rel_con", 8'(con_b), 8'h00);
        chk("tmo_rel_exp", 8'(exp_b), 8'h01);
        step();
        chk("tmo_next_con", 8'(con_b), 8'h10);
        chk("tmo_next_cod", 8'(cod_b), 8'h05);
        chk("tmo_next_exp", 8'(exp_b), 8'h00);

        // Drop + liberar coinciding with the timeout is a normal release
        do_reset();
        sol_b = 7'b0000100;
        step();
        chk("coin_cod", 8'(cod_b), 8'h03);
        step();
        step();
        sol_b = 7'b0000000;
        lib_b = 1'b1;
        step();
        lib_b = 1'b0;
        chk("coin_con", 8'(con_b), 8'h00);
        chk("coin_ocu", 8'(ocu_b), 8'h00);
        chk("coin_exp", 8'(exp_b), 8'h00);
        step();
        chk("coin_exp2", 8'(exp_b), 8'h00);

        // Asynchronous reset mid-grant
        do_reset();
        sol_a = 7'b1000000;
        step();
        chk("ar_cod", 8'(cod_a), 8'h07);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_con", 8'(con_a), 8'h00);
        chk("ar_cod0", 8'(cod_a), 8'h00);
        chk("ar_ocu", 8'(ocu_a), 8'h00);
        sol_a = 7'b1000001;
        step();
        rst = 1'b0;
        step();
        chk("ar_first_cod", 8'(cod_a), 8'h01);
        chk("ar_first_con", 8'(con_a), 8'h01);
        sol_a = '0;

        // MAX_HOLD=0: grant never times out
        do_reset();
        sol_c = 7'b0000010;
        for (int i = 0; i < 300; i++) begin
            step();
            chk("nohold_con", 8'(con_c), 8'h02);
            chk("nohold_exp", 8'(exp_c), 8'h00);
        end
        chk("nohold_cod", 8'(cod_c), 8'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
